// File: rtl/prog_rom_loader_pkg.sv
// Shared definitions for the test CPU instruction memory.
// Holds the instruction width, the NOP opcode and the default instruction
// so that the ROM, the decoder and the bench agree, plus the loader FSM
// state encodings and the bytes-per-word helper.
package prog_rom_loader_pkg;

  localparam int INSTR_W_DEF = 28;

  // Opcode occupies the top 4 bits of an instruction.
  localparam logic [3:0] OP_NOP = 4'hF;

  localparam logic [INSTR_W_DEF-1:0] DEFAULT_INSTR_DEF = {OP_NOP, 24'd0};

  // Loader FSM encodings (also visible on dbg_state).
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Number of bytes needed to carry one instruction word.
  function automatic int bytes_per_word(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/prog_byte_assembler.sv
// Byte-serial to word assembler for the program loader.
// Bytes arrive MSB-first and are shifted into an INSTR_W-wide register; the
// surplus high bits of the first byte fall off the top of the register.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   clear          : restart framing at the beginning of a load
//   byte_data      : incoming byte
//   byte_xfer      : byte_data transfers this cycle
//   word           : assembled word (complete in the cycle after word_done)
//   word_done      : the transfer this cycle is the last byte of a word
module prog_byte_assembler #(
  parameter int INSTR_W = 28,
  parameter int BPW     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [7:0]         byte_data,
  input  logic               byte_xfer,
  output logic [INSTR_W-1:0] word,
  output logic               word_done
);

  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0] byte_cnt;

  assign word_done = byte_xfer && (byte_cnt == CNT_W'(BPW - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (byte_xfer) begin
      word     <= {word[INSTR_W-9:0], byte_data};
      byte_cnt <= word_done ? '0 : byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prog_rom_loader.sv
// Instruction memory for the test CPU with a registered fetch port and an
// in-system byte-serial program loader.
// Ports:
//   Clock, Reset                : clock, synchronous active-high reset
//   iAddress, iFetchEnable      : fetch request (served unless a load is busy)
//   oInstruction, oInstructionValid : registered fetch result, one cycle later
//   iLoadStart, iLoadLength     : start pulse and word count (0 = DEPTH)
//   iByte, iByteValid, oByteReady : loader byte stream
//   oLoadBusy, oLoadDone, oWordCount : loader status
//   dbg_state                   : loader FSM state
// Byte handshake: a byte transfers on a rising edge where iByteValid and
// oByteReady are both high; oByteReady is high only while collecting bytes,
// and iByteValid without oByteReady is simply dropped.
module prog_rom_loader
  import prog_rom_loader_pkg::*;
#(
  parameter int                   INSTR_W       = INSTR_W_DEF,
  parameter int                   ADDR_W        = 16,
  parameter int                   DEPTH         = 64,
  parameter logic [INSTR_W-1:0]   DEFAULT_INSTR = INSTR_W'(DEFAULT_INSTR_DEF),
  parameter string                INIT_FILE     = ""
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  iAddress,
  input  logic               iFetchEnable,
  output logic [INSTR_W-1:0] oInstruction,
  output logic               oInstructionValid,
  input  logic               iLoadStart,
  input  logic [ADDR_W-1:0]  iLoadLength,
  input  logic [7:0]         iByte,
  input  logic               iByteValid,
  output logic               oByteReady,
  output logic               oLoadBusy,
  output logic               oLoadDone,
  output logic [ADDR_W-1:0]  oWordCount,
  output logic [1:0]         dbg_state
);

  localparam int BPW   = bytes_per_word(INSTR_W);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LEN_W = ADDR_W + 1;  // holds DEPTH even when DEPTH == 2**ADDR_W
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  // Power-up image: DEFAULT_INSTR in every word.
  function automatic logic [DEPTH-1:0][INSTR_W-1:0] init_image();
    logic [DEPTH-1:0][INSTR_W-1:0] flat;
    for (int i = 0; i < DEPTH; i++) flat[i] = DEFAULT_INSTR;
    return flat;
  endfunction

  // Contents survive Reset; only the power-up image initialises them.
  logic [DEPTH-1:0][INSTR_W-1:0] mem = init_image();

  logic [1:0]         state;
  logic [PTR_W-1:0]   ptr;
  logic [LEN_W-1:0]   len;
  logic [INSTR_W-1:0] asm_word;
  logic               word_done;
  logic               byte_xfer;
  logic               start_ok;
  logic               busy;
  logic               fetch_ok;
  logic               addr_in_range;
  logic [INSTR_W-1:0] rd_data;

  assign busy       = (state == ST_COLLECT) || (state == ST_WRITE);
  assign oLoadBusy  = busy;
  assign oByteReady = (state == ST_COLLECT);
  assign oLoadDone  = (state == ST_DONE);
  assign dbg_state  = state;
  assign byte_xfer  = iByteValid && oByteReady;
  assign start_ok   = (state == ST_IDLE) && iLoadStart;

  // A fetch in the iLoadStart cycle still sees IDLE and is served from the
  // old contents; blocking begins once the FSM is in COLLECT.
  assign fetch_ok      = iFetchEnable && !busy;
  assign addr_in_range = {1'b0, iAddress} < DEPTH_L;
  assign rd_data       = addr_in_range ? mem[iAddress[PTR_W-1:0]] : DEFAULT_INSTR;

  prog_byte_assembler #(
    .INSTR_W (INSTR_W),
    .BPW     (BPW)
  ) u_asm (
    .clk       (Clock),
    .reset     (Reset),
    .clear     (start_ok),
    .byte_data (iByte),
    .byte_xfer (byte_xfer),
    .word      (asm_word),
    .word_done (word_done)
  );

  // Registered read port; shows DEFAULT_INSTR while a load owns the memory.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oInstruction      <= DEFAULT_INSTR;
      oInstructionValid <= 1'b0;
    end else begin
      oInstructionValid <= fetch_ok;
      if (fetch_ok) begin
        oInstruction <= rd_data;
      end else if (busy) begin
        oInstruction <= DEFAULT_INSTR;
      end
    end
  end

  // Write port: the assembled word is complete during WRITE.
  always_ff @(posedge Clock) begin
    if (state == ST_WRITE) begin
      mem[ptr] <= asm_word;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      len        <= '0;
      oWordCount <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iLoadStart) begin
            // Clamping len keeps ptr inside the implemented words.
            len        <= (iLoadLength == '0 || {1'b0, iLoadLength} > DEPTH_L)
                          ? DEPTH_L : {1'b0, iLoadLength};
            ptr        <= '0;
            oWordCount <= '0;
            state      <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (word_done) state <= ST_WRITE;
        end
        ST_WRITE: begin
          ptr        <= ptr + PTR_W'(1);
          oWordCount <= oWordCount + ADDR_W'(1);
          state      <= (LEN_W'(ptr) + LEN_W'(1) == len) ? ST_DONE : ST_COLLECT;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
